// File: rtl/workload_gen.sv
// -----------------------------------------------------------------------------
// workload_gen
//   Multi-port workload descriptor generator. After a start pulse, every port
//   issues workload_limit_p descriptors {id, size} over valid/ready. Sizes come
//   from a small runtime-writable table. A pacing mode latched at start selects
//   back-to-back issue, a fixed gap after every descriptor, or bursts separated
//   by a gap.
//
// Ports
//   clk_i        clock
//   reset_i      asynchronous, active-high reset
//   cfg_v_i      table write strobe (ignored while a run is in progress)
//   cfg_addr_i   table write address
//   cfg_data_i   table write data
//   start_i      start-run pulse (ignored while a run is in progress)
//   mode_i       pacing: 0 back-to-back, 1 fixed gap, 2 burst, 3 as 0
//   interval_i   gap length in cycles
//   burst_len_i  descriptors per burst in mode 2 (0 behaves as 1)
//   v_o          per-port valid
//   data_o       per-port descriptor, port i at [i*width_p +: width_p], id in MSBs
//   ready_i      per-port ready
//   busy_o       run in progress
//   done_o       all ports finished; held until the next start or reset
// -----------------------------------------------------------------------------
module workload_gen #(
   parameter int  id_width_p       = 3,
   parameter int  size_width_p     = 8,
   parameter int  num_ports_p      = 2,
   parameter int  els_p            = 3,
   parameter int  workload_limit_p = 5,
   parameter int  init_size_p      = 30,
   parameter int  interval_width_p = 16,
   localparam int addr_width_lp    = (els_p > 1) ? $clog2(els_p) : 1,
   localparam int width_p          = id_width_p + size_width_p
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic                             cfg_v_i,
   input  logic [addr_width_lp-1:0]         cfg_addr_i,
   input  logic [size_width_p-1:0]          cfg_data_i,
   input  logic                             start_i,
   input  logic [1:0]                       mode_i,
   input  logic [interval_width_p-1:0]      interval_i,
   input  logic [interval_width_p-1:0]      burst_len_i,
   output logic [num_ports_p-1:0]           v_o,
   output logic [num_ports_p*width_p-1:0]   data_o,
   input  logic [num_ports_p-1:0]           ready_i,
   output logic                             busy_o,
   output logic                             done_o
);

   typedef enum logic [1:0] {G_IDLE, G_RUN, G_DONE} gstate_e;
   typedef enum logic [1:0] {P_IDLE, P_ISSUE, P_GAP, P_FIN} pstate_e;

   localparam logic [id_width_p-1:0]    limit_lp     = id_width_p'(workload_limit_p);
   localparam logic [addr_width_lp-1:0] addr_max_lp  = addr_width_lp'(els_p - 1);
   localparam logic [addr_width_lp:0]   els_lp       = (addr_width_lp + 1)'(els_p);
   localparam logic [size_width_p-1:0]  init_size_lp = size_width_p'(init_size_p / num_ports_p);

   gstate_e                     gstate_q, gstate_d;
   logic [1:0]                  mode_q, mode_d;
   logic [interval_width_p-1:0] ival_q, ival_d;
   logic [interval_width_p-1:0] blen_q, blen_d;

   pstate_e                     pstate_q [num_ports_p];
   pstate_e                     pstate_d [num_ports_p];
   logic [id_width_p-1:0]       id_q     [num_ports_p];
   logic [id_width_p-1:0]       id_d     [num_ports_p];
   logic [addr_width_lp-1:0]    addr_q   [num_ports_p];
   logic [addr_width_lp-1:0]    addr_d   [num_ports_p];
   logic [interval_width_p-1:0] gap_q    [num_ports_p];
   logic [interval_width_p-1:0] gap_d    [num_ports_p];
   logic [interval_width_p-1:0] burst_q  [num_ports_p];
   logic [interval_width_p-1:0] burst_d  [num_ports_p];

   logic [size_width_p-1:0]     tbl_q    [els_p];

   logic                        start_run;
   logic                        tbl_we;
   logic                        all_fin;
   logic [interval_width_p-1:0] blen_eff;

   // Start and table writes are both locked out only while running, so a
   // write in the same cycle as a start lands before the first read.
   assign start_run = start_i && (gstate_q != G_RUN);
   assign tbl_we    = cfg_v_i && (gstate_q != G_RUN) && ({1'b0, cfg_addr_i} < els_lp);
   assign blen_eff  = (blen_q == '0) ? interval_width_p'(1) : blen_q;

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before any branch so no path
      // leaves it unassigned, which would otherwise infer a latch.
      gstate_d = gstate_q;
      mode_d   = mode_q;
      ival_d   = ival_q;
      blen_d   = blen_q;
      pstate_d = pstate_q;
      id_d     = id_q;
      addr_d   = addr_q;
      gap_d    = gap_q;
      burst_d  = burst_q;
      all_fin  = 1'b1;

      if (start_run) begin
         gstate_d = G_RUN;
         mode_d   = mode_i;
         ival_d   = interval_i;
         blen_d   = burst_len_i;
         for (int i = 0; i < num_ports_p; i++) begin
            pstate_d[i] = P_ISSUE;
            id_d[i]     = '0;
            addr_d[i]   = addr_width_lp'(i % els_p);
            gap_d[i]    = '0;
            burst_d[i]  = '0;
         end
      end else if (gstate_q == G_RUN) begin
         for (int i = 0; i < num_ports_p; i++) begin
            case (pstate_q[i])
               P_ISSUE: begin
                  // v_o is high throughout ISSUE, so ready alone is the handshake.
                  if (ready_i[i]) begin
                     id_d[i]   = id_q[i] + id_width_p'(1);
                     addr_d[i] = (addr_q[i] == addr_max_lp) ? '0
                                                            : addr_q[i] + addr_width_lp'(1);
                     if (id_q[i] + id_width_p'(1) == limit_lp) begin
                        pstate_d[i] = P_FIN;
                     end else if (mode_q == 2'd1) begin
                        if (ival_q != '0) begin
                           pstate_d[i] = P_GAP;
                           gap_d[i]    = '0;
                        end
                     end else if (mode_q == 2'd2) begin
                        if (burst_q[i] + interval_width_p'(1) >= blen_eff) begin
                           burst_d[i] = '0;
                           if (ival_q != '0) begin
                              pstate_d[i] = P_GAP;
                              gap_d[i]    = '0;
                           end
                        end else begin
                           burst_d[i] = burst_q[i] + interval_width_p'(1);
                        end
                     end
                  end
               end
               P_GAP: begin
                  // Counts 0..interval-1, giving exactly interval idle cycles.
                  if (gap_q[i] == ival_q - interval_width_p'(1)) begin
                     pstate_d[i] = P_ISSUE;
                     gap_d[i]    = '0;
                  end else begin
                     gap_d[i] = gap_q[i] + interval_width_p'(1);
                  end
               end
               default: ;
            endcase
            if (pstate_d[i] != P_FIN) all_fin = 1'b0;
         end
         // Finish in the same edge as the last handshake so done_o and the
         // drop of busy_o appear together with v_o going low.
         if (all_fin) gstate_d = G_DONE;
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge reset_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset_i) begin
         gstate_q <= G_IDLE;
         mode_q   <= '0;
         ival_q   <= '0;
         blen_q   <= '0;
         for (int i = 0; i < num_ports_p; i++) begin
            pstate_q[i] <= P_IDLE;
            id_q[i]     <= '0;
            addr_q[i]   <= '0;
            gap_q[i]    <= '0;
            burst_q[i]  <= '0;
         end
      end else begin
         gstate_q <= gstate_d;
         mode_q   <= mode_d;
         ival_q   <= ival_d;
         blen_q   <= blen_d;
         pstate_q <= pstate_d;
         id_q     <= id_d;
         addr_q   <= addr_d;
         gap_q    <= gap_d;
         burst_q  <= burst_d;
      end
   end

   // NOTE: the size table is a handful of flops with a defined power-up
   // content, so it takes the reset; a large table in RAM would not.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int e = 0; e < els_p; e++) tbl_q[e] <= init_size_lp;
      end else if (tbl_we) begin
         tbl_q[cfg_addr_i] <= cfg_data_i;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs: decoded from registers only; data is zero whenever not valid.
   // -------------------------------------------------------------------------
   always_comb begin
      v_o    = '0;
      data_o = '0;
      for (int i = 0; i < num_ports_p; i++) begin
         if (pstate_q[i] == P_ISSUE) begin
            v_o[i]                       = 1'b1;
            data_o[i*width_p +: width_p] = {id_q[i], tbl_q[addr_q[i]]};
         end
      end
   end

   assign busy_o = (gstate_q == G_RUN);
   assign done_o = (gstate_q == G_DONE);

endmodule

// File: tb/tb_workload_gen.sv
module tb_workload_gen;

   localparam int IDW  = 3;
   localparam int SZW  = 8;
   localparam int NP   = 2;
   localparam int ELS  = 3;
   localparam int LIM  = 5;
   localparam int INIT = 30;
   localparam int IW   = 16;
   localparam int AW   = 2;
   localparam int W    = IDW + SZW;

   logic            clk = 1'b0;
   logic            rst;
   logic            cfg_v;
   logic [AW-1:0]   cfg_addr;
   logic [SZW-1:0]  cfg_data;
   logic            start;
   logic [1:0]      mode;
   logic [IW-1:0]   interval;
   logic [IW-1:0]   burst_len;
   logic [NP-1:0]   v_o;
   logic [NP*W-1:0] data_o;
   logic [NP-1:0]   ready;
   logic            busy_o;
   logic            done_o;

   workload_gen #(
      .id_width_p(IDW), .size_width_p(SZW), .num_ports_p(NP), .els_p(ELS),
      .workload_limit_p(LIM), .init_size_p(INIT), .interval_width_p(IW)
   ) dut (
      .clk_i(clk), .reset_i(rst), .cfg_v_i(cfg_v), .cfg_addr_i(cfg_addr),
      .cfg_data_i(cfg_data), .start_i(start), .mode_i(mode), .interval_i(interval),
      .burst_len_i(burst_len), .v_o(v_o), .data_o(data_o), .ready_i(ready),
      .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Model: each port has a count of issued descriptors and the earliest cycle
   // at which it may present the next one.
   // ---------------------------------------------------------------------------
   bit     m_run, m_done;
   int     m_mode, m_ival, m_blen;
   int     issued   [NP];
   longint ready_at [NP];
   longint cyc;
   int     tbl_m    [ELS];
   int     gap;
   bit     all_done;

   function automatic bit exp_v(int i);
      return m_run && (issued[i] < LIM) && (cyc >= ready_at[i]);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_run  = 0;
         m_done = 0;
         cyc    = 0;
         for (int i = 0; i < NP; i++) begin
            issued[i]   = 0;
            ready_at[i] = 0;
         end
         for (int e = 0; e < ELS; e++) tbl_m[e] = INIT / NP;
      end else begin
         if (m_run) begin
            for (int i = 0; i < NP; i++) begin
               if (exp_v(i) && ready[i]) begin
                  issued[i]++;
                  gap = 0;
                  if (m_mode == 1) gap = m_ival;
                  else if (m_mode == 2 && (issued[i] % ((m_blen == 0) ? 1 : m_blen)) == 0)
                     gap = m_ival;
                  ready_at[i] = cyc + 1 + gap;
               end
            end
         end
         if (cfg_v && !m_run && int'(cfg_addr) < ELS) tbl_m[cfg_addr] = int'(cfg_data);
         if (start && !m_run) begin
            m_run  = 1;
            m_done = 0;
            m_mode = int'(mode);
            m_ival = int'(interval);
            m_blen = int'(burst_len);
            for (int i = 0; i < NP; i++) begin
               issued[i]   = 0;
               ready_at[i] = cyc + 1;
            end
         end else if (m_run) begin
            all_done = 1;
            for (int i = 0; i < NP; i++) if (issued[i] < LIM) all_done = 0;
            if (all_done) begin
               m_run  = 0;
               m_done = 1;
            end
         end
         cyc++;
      end
   end

   // Compare process: mid-cycle, every cycle out of reset.
   logic [NP-1:0] ev;
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NP; i++) ev[i] = exp_v(i);
         check("v_o", 64'(v_o), 64'(ev));
         check("busy_o", 64'(busy_o), 64'(m_run));
         check("done_o", 64'(done_o), 64'(m_done));
         for (int i = 0; i < NP; i++)
            if (ev[i])
               check($sformatf("data_o[%0d]", i), 64'(data_o[i*W +: W]),
                     64'({IDW'(issued[i]), SZW'(tbl_m[(i + issued[i]) % ELS])}));
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus (inputs change on the falling edge)
   // ---------------------------------------------------------------------------
   task automatic start_run(input logic [1:0] m, input int iv, input int bl);
      mode      = m;
      interval  = IW'(iv);
      burst_len = IW'(bl);
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc);
      int k;
      k = 0;
      while (!done_o && k < max_cyc) begin
         @(negedge clk);
         k++;
      end
      check("done_reached", 64'(done_o), 64'd1);
   endtask

   logic [14:0] ids;
   logic [39:0] sizes;
   logic [7:0]  pat;

   initial begin
      rst = 1'b1; cfg_v = 0; cfg_addr = '0; cfg_data = '0; start = 0;
      mode = '0; interval = '0; burst_len = '0; ready = '0;
      #12;
      check("rst_v", 64'(v_o), 64'd0);
      check("rst_data", 64'(data_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_done", 64'(done_o), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Mode 0, ready high: ids 0..4 back-to-back, done one cycle after.
      ready = 2'b11;
      start_run(2'd0, 0, 0);
      check("t1_first", 64'(data_o[W-1:0]), 64'({3'd0, 8'd15}));
      check("t1_busy", 64'(busy_o), 64'd1);
      for (int k = 0; k < 5; k++) begin
         ids[k*3 +: 3] = data_o[W-1 -: IDW];
         @(negedge clk);
      end
      check("t1_ids", 64'(ids), 64'({3'd4, 3'd3, 3'd2, 3'd1, 3'd0}));
      check("t1_done", 64'(done_o), 64'd1);
      check("t1_v_low", 64'(v_o), 64'd0);

      // Mode 1, interval 3: one high then three low.
      start_run(2'd1, 3, 0);
      for (int k = 0; k < 8; k++) begin
         pat[k] = v_o[0];
         @(negedge clk);
      end
      check("t2_pattern", 64'(pat), 64'(8'b0001_0001));
      wait_done(100);

      // Mode 2, burst 2, interval 2: high,high,low,low.
      start_run(2'd2, 2, 2);
      for (int k = 0; k < 8; k++) begin
         pat[k] = v_o[0];
         @(negedge clk);
      end
      check("t3_pattern", 64'(pat), 64'(8'b0011_0011));
      wait_done(100);

      // Mode 2, burst_len 0 acts as 1, interval 1: alternating.
      start_run(2'd2, 1, 0);
      for (int k = 0; k < 4; k++) begin
         pat[k] = v_o[0];
         @(negedge clk);
      end
      check("t4_pattern", 64'(pat[3:0]), 64'(4'b0101));
      wait_done(100);

      // Mode 3 behaves as mode 0 even with a nonzero interval.
      start_run(2'd3, 5, 0);
      for (int k = 0; k < 5; k++) begin
         pat[k] = v_o[0];
         @(negedge clk);
      end
      check("t5_pattern", 64'(pat[4:0]), 64'(5'b11111));
      wait_done(100);

      // Mode 1 with interval 0 is back-to-back.
      start_run(2'd1, 0, 0);
      wait_done(100);

      // Table load; the last write shares its cycle with start.
      cfg_v = 1'b1; cfg_addr = 2'd1; cfg_data = 8'd20;
      @(negedge clk);
      cfg_addr = 2'd2; cfg_data = 8'd30;
      @(negedge clk);
      cfg_addr = 2'd0; cfg_data = 8'd10;
      start_run(2'd0, 0, 0);
      cfg_v = 1'b0;
      for (int k = 0; k < 5; k++) begin
         sizes[k*8 +: 8] = data_o[SZW-1:0];
         // This write lands during the run and must be dropped.
         cfg_v = (k == 1); cfg_addr = 2'd0; cfg_data = 8'd99;
         @(negedge clk);
      end
      cfg_v = 1'b0;
      check("t7_sizes", 64'(sizes), 64'({8'd20, 8'd10, 8'd30, 8'd20, 8'd10}));
      wait_done(100);

      // Port 0 stalled: descriptor held, then exactly one handshake.
      ready = 2'b10;
      start_run(2'd0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         check("t8_hold", 64'(data_o[W-1:0]), 64'({3'd0, 8'd10}));
         @(negedge clk);
      end
      ready = 2'b11;
      @(negedge clk);
      ready = 2'b10;
      check("t8_one_hs", 64'(data_o[W-1:0]), 64'({3'd1, 8'd20}));
      @(negedge clk);
      check("t8_still", 64'(data_o[W-1:0]), 64'({3'd1, 8'd20}));
      ready = 2'b11;
      wait_done(100);

      // Asynchronous reset mid-run at id 2.
      start_run(2'd0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      ready = 2'b00;
      check("t9_id2", 64'(data_o[W-1:0]), 64'({3'd2, 8'd30}));
      #2 rst = 1'b1;
      #1;
      check("t9_async_v", 64'(v_o), 64'd0);
      check("t9_async_data", 64'(data_o), 64'd0);
      check("t9_async_busy", 64'(busy_o), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("t9_no_resume", 64'(v_o), 64'd0);
      ready = 2'b11;
      start_run(2'd0, 0, 0);
      check("t9_restart", 64'(data_o[W-1:0]), 64'({3'd0, 8'd15}));
      wait_done(100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/workload_gen.md
# workload_gen

Parametrised multi-port workload generator for accelerator test benches. Each port issues a sequence of workload descriptors {workload id, size} over a valid/ready interface. Sizes come from a size table that can be rewritten at runtime, and a programmable pacing mode controls when descriptors are issued. Successor to the single-mode data generator: it adds runtime table load, start/done control, burst pacing, and valid-hold-until-ready semantics.

## Interface
- id_width_p, none: width of the per-port workload id; must satisfy 2^id_width_p > workload_limit_p
- size_width_p, none: width of a size entry
- num_ports_p, none: number of independent output ports
- els_p, none (>=2): size-table depth
- workload_limit_p, none (>=1): descriptors issued per port per run
- init_size_p, none: reset value of every table entry is init_size_p / num_ports_p (integer division)
- interval_width_p, 16: width of interval_i and burst_len_i
- addr_width_lp, `BSG_SAFE_CLOG2(els_p)`: table address width (derived)
- width_p, id_width_p+size_width_p: descriptor width (derived)

Ports:
- clk_i  in  1  clock; the block's only clock
- reset_i  in  1  reset; asynchronous, active-high
- cfg_v_i  in  1  table write strobe
- cfg_addr_i  in  addr_width_lp  table write address
- cfg_data_i  in  size_width_p  table write data
- start_i  in  1  start-run pulse
- mode_i  in  2  pacing mode: 0 back-to-back, 1 fixed gap, 2 burst, 3 reserved (behaves as 0)
- interval_i  in  interval_width_p  gap length in cycles
- burst_len_i  in  interval_width_p  descriptors per burst (mode 2)
- v_o  out  num_ports_p  per-port valid
- data_o  out  num_ports_p x width_p  per-port descriptor {id, size}; id in the MSBs
- ready_i  in  num_ports_p  per-port ready
- busy_o  out  1  run in progress
- done_o  out  1  all ports have issued workload_limit_p descriptors

## Operation
- Global state IDLE -> RUN -> DONE. A start_i pulse in IDLE or DONE enters RUN. start_i is ignored while in RUN.
- Entering RUN latches mode_i, interval_i and burst_len_i. For each port i: id=0, addr = i mod els_p, gap counter=0, burst counter=0.
- Per-port FSM states are ISSUE, GAP and FIN.
  - ISSUE: v_o[i]=1 and data_o[i]={id, table[addr]}. Both stay stable until handshake (v_o & ready_i).
  - On handshake: id++. addr++ with wrap from els_p-1 to 0. If the new id equals workload_limit_p, go to FIN.
  - Mode 1 with interval > 0: go to GAP for interval cycles, then return to ISSUE.
  - Mode 2: burst counter++. When it reaches burst_len_i, clear it and go to GAP (skip GAP if interval=0). burst_len_i=0 is treated as 1.
  - Mode 0/3: stay in ISSUE.
  - FIN: v_o[i]=0.
- done_o is set when every port is in FIN. The block then moves to DONE and clears busy_o. done_o holds until the next start or reset.
- Table writes occur only when cfg_v_i is high and the block is not in RUN. Writes during RUN are dropped. A write and a start in the same cycle: the write lands, and the run reads the new value.
- The table resets to init_size_p/num_ports_p in every entry. The table is not cleared on start.

## Timing
- Reset values: v_o=0, data_o=0, busy_o=0, done_o=0, global state IDLE, all ids/addrs/counters 0, table = init value.
- Reset is asynchronous: all state clears immediately, including mid-run and mid-handshake. The run does not resume after reset.
- start_i sampled high at edge t -> busy_o=1 and v_o=all-ones from cycle t+1.
- Mode 0: after a handshake at edge t, the next descriptor is valid in cycle t+1, so a port with continuously high ready sustains 1 descriptor/cycle.
- Mode 1, interval N: handshake at edge t -> v_o low in cycles t+1..t+N, high again at t+N+1.
- Last handshake of the last port at edge t -> v_o low and done_o=1 from t+1, busy_o=0 in the same cycle.
- Registered outputs only; there is no combinational path from ready_i to v_o or data_o.

## Test plan
- Reset then start, mode 0, num_ports_p=2, workload_limit_p=4, ready always 1 -> each port issues ids 0,1,2,3 on 4 consecutive cycles; done_o rises at cycle 5 after start.
- Mode 1, interval=3, ready always 1 -> valid pulses 1 cycle high then 3 low; handshakes 4 cycles apart.
- Mode 2, burst_len=2, interval=2 -> pattern high,high,low,low; ids advance only on the high cycles.
- Ready held low 5 cycles with v_o high -> data_o unchanged for all 5 cycles; a single handshake occurs when ready rises.
- Load table {10,20,30} (els_p=3), workload_limit_p=5, port 0 -> sizes 10,20,30,10,20 (wrap). A cfg write during RUN leaves the table unchanged.
- Assert reset_i mid-run at id=2 -> v_o drops without a clock edge; after release, v_o stays 0 until start; the restart begins at id 0.
